// File: rtl/cond_sum_pipe.sv
// cond_sum_pipe: pipelined conditional-sum adder/subtractor with carry chaining.
// Ports:
//    clk, rst_n              clock (rising edge), asynchronous active-low reset
//    in_valid, in_ready      input handshake; an operation is taken on in_valid & in_ready
//    a, b, cin, sub          operands, explicit carry-in, subtract select (B inverted)
//    use_carry               take carry-in from the final carry of the last completed result
//    out_valid, out_ready    output handshake; a result completes on out_valid & out_ready
//    sum, cout, ovf, zero    result, raw MSB carry, signed overflow, sum == 0
module cond_sum_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             use_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int SW = WIDTH / STAGES;
   localparam int NS = SW / 8;
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             creg, ovf_q, zero_q, stall, done, accept, pending, c0;
   logic [WIDTH-1:0] b_eff;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign stall     = out_valid & ~out_ready;
   assign done      = out_valid & out_ready;
   // Older work still in flight after this edge: everything if frozen, otherwise
   // whatever shifts forward without leaving through the output.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < STAGES; i++)
         pending = pending | (v_q[i] & (stall | (i < STAGES - 1)));
   end
   assign in_ready = ~stall & ~(use_carry & pending);
   assign accept   = in_valid & in_ready;
   assign b_eff    = sub ? ~b : b;
   // A result retiring this cycle forwards its carry straight into a chained op.
   assign c0       = use_carry ? (done ? cout : creg) : (sub | cin);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) creg <= 1'b0;
      else if (done) creg <= cout;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic [WIDTH-1:k*SW] ai, bi;
      logic [WIDTH-1:0]    si, ns;
      logic                ci, vi, c;
      logic [8:0]          t0, t1;
      if (k == 0) begin : g_in
         assign ai = a;
         assign bi = b_eff;
         assign si = '0;
         assign ci = c0;
         assign vi = accept;
      end else begin : g_in
         assign ai = a_q[k-1][WIDTH-1:k*SW];
         assign bi = b_q[k-1][WIDTH-1:k*SW];
         assign si = s_q[k-1];
         assign ci = c_q[k-1];
         assign vi = v_q[k-1];
      end
      // Each 8-bit slice forms both carry-in candidates; the rippling carry picks one.
      always_comb begin
         ns = si;
         c  = ci;
         t0 = '0;
         t1 = '0;
         for (int j = 0; j < NS; j++) begin
            t0 = {1'b0, ai[k*SW+8*j +: 8]} + {1'b0, bi[k*SW+8*j +: 8]};
            t1 = {1'b0, ai[k*SW+8*j +: 8]} + {1'b0, bi[k*SW+8*j +: 8]} + 9'd1;
            ns[k*SW+8*j +: 8] = c ? t1[7:0] : t0[7:0];
            c = c ? t1[8] : t0[8];
         end
      end
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            v_q[k] <= 1'b0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end else if (!stall) begin
            v_q[k] <= vi;
            s_q[k] <= ns;
            c_q[k] <= c;
         end
      if (k < STAGES - 1) begin : g_op
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               a_q[k] <= '0;
               b_q[k] <= '0;
            end else if (!stall) begin
               a_q[k][WIDTH-1:k*SW] <= ai;
               b_q[k][WIDTH-1:k*SW] <= bi;
            end
      end else begin : g_flag
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (!stall) begin
               ovf_q  <= (ai[WIDTH-1] == bi[WIDTH-1]) & (ns[WIDTH-1] != ai[WIDTH-1]);
               zero_q <= ns == '0;
            end
      end
   end
endmodule

// File: tb/tb_cond_sum_pipe.sv
// tb_cond_sum_pipe: scoreboard bench for cond_sum_pipe (WIDTH=32, STAGES=2).
module tb_cond_sum_pipe;
   localparam int W = 32;
   localparam int S = 2;
   typedef struct {
      logic [W-1:0] s;
      logic         c, o, z;
      int           acc_cyc;
      int           acc_stall;
   } exp_t;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0, use_carry = 1'b0;
   logic         out_valid, out_ready = 1'b1, cout, ovf, zero;
   logic [W-1:0] a = '0, b = '0, sum;
   exp_t         q[$];
   int           checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
   logic         model_creg = 1'b0, was_stall = 1'b0, rand_done = 1'b0;
   logic [W-1:0] hold_sum;
   logic [2:0]   hold_f;
   cond_sum_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .use_carry(use_carry),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   // Presents one op, waits (bounded) for acceptance and pushes the reference result.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                       input logic tsub, input logic tuc);
      int           n = 0;
      logic [W-1:0] be;
      logic         c0;
      logic [W:0]   r;
      exp_t         e;
      a = ta; b = tb; cin = tcin; sub = tsub; use_carry = tuc; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", in_ready, 1);
      else begin
         be = tsub ? ~tb : tb;
         c0 = tuc ? model_creg : (tsub | tcin);
         r = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, c0};
         e.s = r[W-1:0];
         e.c = r[W];
         e.o = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
         e.z = r[W-1:0] == '0;
         e.acc_cyc = cyc;
         e.acc_stall = stall_cnt;
         q.push_back(e);
         model_creg = e.c;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
      #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && !out_ready) begin
            stall_cnt++;
            check("ready_in_stall", in_ready, 0);
            if (was_stall) begin
               check("hold_sum", sum, hold_sum);
               check("hold_flags", {cout, ovf, zero}, hold_f);
            end
            hold_sum = sum;
            hold_f = {cout, ovf, zero};
            was_stall = 1'b1;
         end else was_stall = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_out", out_valid, 0);
            else begin
               e = q.pop_front();
               check("sum", sum, e.s);
               check("cout", cout, e.c);
               check("ovf", ovf, e.o);
               check("zero", zero, e.z);
               check("latency", cyc - e.acc_cyc, S + stall_cnt - e.acc_stall);
            end
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_flags", {cout, ovf, zero}, 3'b000);
      check("rst_creg", dut.creg, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
      drain();
      check("creg_before_reset", dut.creg, 1);
      send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_creg", dut.creg, 0);
      q.delete();
      model_creg = 1'b0;
      was_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(32'd5, 32'd3, 1'b0, 1'b0, 1'b1);
      drain();
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      a = '0; b = '0; cin = 1'b0; sub = 1'b0; use_carry = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check("interlock", in_ready, 0);
      @(posedge clk);
      #1 send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
      send(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b1);
      drain();
      fork
         begin
            send(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
            send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, 1'b0);
            send(32'h7000_0000, 32'h7000_0000, 1'b1, 1'b0, 1'b0);
            send(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      fork
         begin
            for (int i = 0; i < 300; i++)
               send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = $urandom_range(0, 3) != 0;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
